// File: rtl/mux_gate_serial_ctrl_if.sv
// mux_gate_serial_ctrl_if: request/result handshake bundle for the serial mux-gate sequencer
interface mux_gate_serial_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             err;
  logic             busy;
  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, y, err, busy);
  modport slave (input in_valid, op, a, b, out_ready, output in_ready, out_valid, y, err, busy);
endinterface

// File: rtl/mux_gate_serial_ctrl.sv
// mux_gate_serial_ctrl: steps one 2:1-mux logic cell across two operands, LSB first
module mux_gate_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  mux_gate_serial_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_y;
  logic [2:0]       r_op;
  logic             r_err;
  logic [CW-1:0]    r_cnt;
  logic             w_s, w_d, w_bit, w_acc, w_last;
  assign w_acc  = (r_state == IDLE) & bus.in_valid;
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && w_acc)          ? RUN  :
             (r_state == RUN  && w_last)         ? DONE :
             (r_state == DONE && bus.out_ready)  ? IDLE : r_state;
  end
  always_comb begin
    bus.in_ready  = r_state == IDLE;
    bus.out_valid = r_state == DONE;
    bus.busy      = r_state != IDLE;
    bus.y         = r_y;
    bus.err       = r_err;
  end
  // the shared cell: a operand bit is the select, b operand bit is the data
  always_comb begin
    w_s   = r_a[r_cnt];
    w_d   = r_b[r_cnt];
    w_bit = (r_op == 3'd0) ? (w_s ? w_d   : 1'b0) :
            (r_op == 3'd1) ? (w_s ? 1'b1  : w_d)  :
            (r_op == 3'd2) ? (w_s ? 1'b0  : ~w_d) :
            (r_op == 3'd3) ? (w_s ? ~w_d  : 1'b1) :
            (r_op == 3'd4) ? (w_s ? w_d   : ~w_d) :
            (r_op == 3'd5) ? (w_s ? ~w_d  : w_d)  : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_y   <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_op  <= bus.op;
      r_y   <= '0;
      r_err <= bus.op > 3'd5;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_y[r_cnt] <= w_bit;
      if (!w_last) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_gate_serial_ctrl.sv
// tb_mux_gate_serial_ctrl: directed checks of the serial mux-gate sequencer
module tb_mux_gate_serial_ctrl;
  logic clk, rst;
  int   vecs, miss, n;
  mux_gate_serial_ctrl_if #(.WIDTH(8)) bus ();
  mux_gate_serial_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] ey, input logic ee);
    int c;
    bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_out(c);
    chk({tag, "_lat"}, 32'(c), 32'd8);
    chk({tag, "_y"}, 32'(bus.y), 32'(ey));
    chk({tag, "_err"}, 32'(bus.err), 32'(ee));
    tick();
    chk({tag, "_rdy"}, {bus.in_ready, bus.out_valid}, 32'b10);
  endtask
  initial begin
    vecs = 0; miss = 0;
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0; bus.op = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_flags", {bus.in_ready, bus.out_valid, bus.busy, bus.err}, 32'b1000);
    chk("rst_y", 32'(bus.y), 32'h0);
    run_op("and",  8'hA5, 8'h3C, 3'd0, 8'h24, 1'b0);
    chk("and_hold_y", 32'(bus.y), 32'h24);
    run_op("or",   8'hA5, 8'h3C, 3'd1, 8'hBD, 1'b0);
    run_op("nor",  8'hA5, 8'h3C, 3'd2, 8'h42, 1'b0);
    run_op("nand", 8'hA5, 8'h3C, 3'd3, 8'hDB, 1'b0);
    run_op("xnor", 8'hA5, 8'h3C, 3'd4, 8'h66, 1'b0);
    run_op("xor",  8'hFF, 8'h0F, 3'd5, 8'hF0, 1'b0);
    run_op("ill",  8'hFF, 8'hFF, 3'd6, 8'h00, 1'b1);
    run_op("clr",  8'hA5, 8'h3C, 3'd0, 8'h24, 1'b0);
    // backpressure with an ignored request arriving while DONE
    bus.out_ready = 1'b0;
    bus.a = 8'hA5; bus.b = 8'h3C; bus.op = 3'd1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_out(n);
    chk("bp_lat", 32'(n), 32'd8);
    bus.a = 8'h00; bus.b = 8'hFF; bus.op = 3'd0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {bus.out_valid, bus.in_ready, bus.err, bus.y}, {3'b100, 8'hBD});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_xfer", {bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
    tick();
    chk("bp_idle", {bus.in_ready, bus.busy, bus.y}, {2'b10, 8'hBD});
    // reset after three bits have been written
    bus.a = 8'hA5; bus.b = 8'h3C; bus.op = 3'd0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid_partial_y", 32'(bus.y), 32'h04);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst", {bus.in_ready, bus.out_valid, bus.busy, bus.err, bus.y}, {4'b1000, 8'h00});
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n += int'(bus.out_valid);
    end
    chk("mid_no_result", 32'(n), 32'd0);
    // back-to-back: second request held until in_ready returns
    bus.a = 8'hA5; bus.b = 8'h3C; bus.op = 3'd5; bus.in_valid = 1'b1;
    tick();
    bus.a = 8'hFF; bus.b = 8'h0F; bus.op = 3'd0;
    wait_out(n);
    chk("b2b_lat1", 32'(n), 32'd8);
    chk("b2b_y1", 32'(bus.y), 32'h99);
    tick();
    chk("b2b_idle", {bus.in_ready, bus.busy}, 32'b10);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_acc2", {bus.in_ready, bus.busy}, 32'b01);
    wait_out(n);
    chk("b2b_lat2", 32'(n), 32'd8);
    chk("b2b_y2", {bus.err, bus.y}, {1'b0, 8'h0F});
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
